// File: rtl/symbol_sequence_tx.sv
// symbol_sequence_tx: FIFO-fed 2-bit symbol transmitter; each queued symbol is driven for hold+1 cycles.
// Optional SYMTX_LOOP_EN adds a loop input that replays the queue forever.
module symbol_sequence_tx #(
    parameter int         DEPTH    = 4,
    parameter int         HOLD_W   = 4,
    parameter logic [1:0] IDLE_SYM = 2'b00
) (
    input  logic                   clk,
    input  logic                   init,
`ifdef SYMTX_LOOP_EN
    input  logic                   loop,
`endif
    input  logic                   wr_valid,
    input  logic [1:0]             wr_sym,
    input  logic [HOLD_W-1:0]      wr_hold,
    output logic                   wr_ready,
    output logic [1:0]             sym_out,
    output logic                   sym_start,
    output logic                   busy,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE = 2'b00, HOLD = 2'b01} state_t;
    state_t            st, st_d;
    logic [HOLD_W+1:0] mem [DEPTH];
    logic [HOLD_W+1:0] head, wr_data;
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [HOLD_W-1:0] cnt, cnt_d;
    logic [1:0]        sym_d;
    logic              start_d, busy_d, pop, push, wr_en, loop_on;
`ifdef SYMTX_LOOP_EN
    assign loop_on = loop;
`else
    assign loop_on = 1'b0;
`endif
    assign head     = mem[rd_ptr];
    assign wr_ready = (count != CW'(DEPTH)) && !loop_on;
    assign push     = wr_valid && wr_ready;
    assign pop      = (count != '0) && (st == IDLE || cnt == '0);
    // In loop mode the popped entry is written straight back at the tail
    assign wr_en    = push || (pop && loop_on);
    assign wr_data  = push ? {wr_sym, wr_hold} : head;
    assign state    = st;
    always_comb begin
        st_d    = st;
        cnt_d   = cnt;
        sym_d   = sym_out;
        start_d = 1'b0;
        busy_d  = busy;
        if (pop) begin
            st_d    = HOLD;
            cnt_d   = head[HOLD_W-1:0];
            sym_d   = head[HOLD_W+1:HOLD_W];
            start_d = 1'b1;
            busy_d  = 1'b1;
        end else if (st == HOLD && cnt != '0) begin
            cnt_d = cnt - HOLD_W'(1);
        end else begin
            st_d   = IDLE;
            sym_d  = IDLE_SYM;
            busy_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (init) begin
            st        <= IDLE;
            cnt       <= '0;
            sym_out   <= IDLE_SYM;
            sym_start <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            st        <= st_d;
            cnt       <= cnt_d;
            sym_out   <= sym_d;
            sym_start <= start_d;
            busy      <= busy_d;
            count     <= count + CW'(wr_en) - CW'(pop);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en && !init) mem[wr_ptr] <= wr_data;
    end
endmodule
